// File: rtl/bitwise_pipe_stage_pkg.sv
// Shared types for the bitwise pipeline stage: opcode encoding and skid-buffer state.
package bitwise_pipe_stage_pkg;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'd0,
    OP_NOT_A  = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_NAND   = 3'd5,
    OP_NOR    = 3'd6,
    OP_XNOR   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/bitwise_pipe_stage_logic.sv
// Combinational opcode decode: c = f(a, b) selected by op.
module bitwise_logic_unit
  import bitwise_pipe_stage_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] c
);

  always_comb begin
    c = '0;
    case (op_e'(op))
      OP_PASS_A: c = a;
      OP_NOT_A:  c = ~a;
      OP_AND:    c = a & b;
      OP_OR:     c = a | b;
      OP_XOR:    c = a ^ b;
      OP_NAND:   c = ~(a & b);
      OP_NOR:    c = ~(a | b);
      OP_XNOR:   c = ~(a ^ b);
      default:   c = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_pipe_stage.sv
// One-cycle bitwise ALU stage with a 2-entry skid buffer; out_c/out_op always show the main entry.
module bitwise_pipe_stage
  import bitwise_pipe_stage_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic [2:0]   out_op
);

  skid_state_e  state;
  logic [N-1:0] res;
  logic [N-1:0] skid_c;
  logic [2:0]   skid_op;
  logic         accept;
  logic         take;

  bitwise_logic_unit #(.N(N)) u_logic (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .c  (res)
  );

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  // in_ready/out_valid are registered alongside state so they are pure flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_op    <= '0;
      skid_c    <= '0;
      skid_op   <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_c     <= res;
            out_op    <= in_op;
            state     <= ST_ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !take) begin
            skid_c   <= res;
            skid_op  <= in_op;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (take && !accept) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end else if (accept && take) begin
            out_c  <= res;
            out_op <= in_op;
          end
        end
        ST_FULL: begin
          if (take) begin
            out_c    <= skid_c;
            out_op   <= skid_op;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_pipe_stage.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_bitwise_pipe_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic [2:0] out_op;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [7:0] c;
    logic [2:0] op;
  } ent_t;

  ent_t       q[$];
  bit         stall;
  logic [7:0] stall_c;

  always #5 clk = ~clk;

  bitwise_pipe_stage #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_op    (out_op)
  );

  function automatic logic [7:0] f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a;
      3'd1:    return ~a;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a & b);
      3'd6:    return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two results.
  always @(posedge clk) begin
    bit acc, tk;
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      acc   = in_valid && (q.size() < 2);
      tk    = (q.size() > 0) && out_ready;
      stall = (q.size() > 0) && !out_ready;
      if (stall) stall_c = q[0].c;
      if (tk) void'(q.pop_front());
      if (acc) q.push_back('{c: f(in_a, in_b, in_op), op: in_op});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("model_out_c", 32'(out_c), 32'(q[0].c));
        chk("model_out_op", 32'(out_op), 32'(q[0].op));
      end
      if (stall) chk("stall_hold", 32'(out_c), 32'(stall_c));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'hA5, 8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_c", 32'(out_c), 32'h00);

    // Opcode sweep, one result per cycle
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      step();
      chk("sweep_c", 32'(out_c), 32'(sweep_exp[i]));
      chk("sweep_op", 32'(out_op), 32'(i));
    end
    drain();

    // Back-pressure into FULL
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd1; in_a = 8'h0F; in_b = 8'h00;
    step();
    chk("bp_first_c", 32'(out_c), 32'hF0);
    in_op = 3'd2; in_a = 8'hFF; in_b = 8'hF0;
    step();
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_c", 32'(out_c), 32'hF0);
    chk("bp_full_op", 32'(out_op), 32'd1);
    step();
    chk("bp_hold_c", 32'(out_c), 32'hF0);
    chk("bp_hold_op", 32'(out_op), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_second_c", 32'(out_c), 32'hF0);
    chk("bp_second_op", 32'(out_op), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Streaming NOT_A
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd1;
    for (int i = 0; i < 16; i++) begin
      in_a = 8'(i);
      step();
      chk("stream_c", 32'(out_c), 32'(8'hFF - 8'(i)));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Simultaneous accept and take in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_a = 8'h11;
    step();
    chk("sim_first_c", 32'(out_c), 32'h11);
    out_ready = 1'b1; in_a = 8'h22;
    step();
    in_valid = 1'b0;
    chk("sim_c", 32'(out_c), 32'h22);
    chk("sim_out_valid", 32'(out_valid), 32'd1);
    chk("sim_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset held two cycles while FULL, with accept/take offered
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd4; in_a = 8'h5A; in_b = 8'hFF;
    repeat (2) step();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_c", 32'(out_c), 32'h00);
    chk("rst_mid_out_op", 32'(out_op), 32'd0);

    // Random valid/ready toggling
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      step();
    end
    drain();
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_pipe_stage.md
BITWISE_PIPE_STAGE -- requirements
Module: bitwise_pipe_stage

Interface
REQ-001 SHALL have parameter N, default 8, giving operand/result width in bits (N >= 1).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-005 SHALL have port in_ready  output  1  stage can accept; driven from a register.
REQ-006 SHALL have port in_a  input  N  operand A.
REQ-007 SHALL have port in_b  input  N  operand B; ignored by PASS_A and NOT_A.
REQ-008 SHALL have port in_op  input  3  opcode.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream takes the result.
REQ-011 SHALL have port out_c  output  N  registered result.
REQ-012 SHALL have port out_op  output  3  opcode that produced out_c.

Function
REQ-013 Opcodes SHALL be: 0 PASS_A (a), 1 NOT_A (~a), 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR; all 8 codes are legal.
REQ-014 Result SHALL be computed combinationally from in_a/in_b/in_op and captured on accept; out_c, out_op SHALL be register outputs only.
REQ-015 Accept SHALL occur in a cycle with in_valid && in_ready; take SHALL occur with out_valid && out_ready.
REQ-016 Storage SHALL be a 2-entry skid buffer (main, skid) with states EMPTY, ONE, FULL; out_c/out_op SHALL always show main.
REQ-017 EMPTY: accept -> ONE (load main); otherwise stay.
REQ-018 ONE: accept and no take -> FULL (load skid); take and no accept -> EMPTY; accept and take -> ONE (reload main); neither -> stay.
REQ-019 FULL: take -> ONE (skid moves to main); otherwise stay; no accept possible.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; out_valid SHALL be 1 in ONE and FULL.
REQ-021 Latency SHALL be 1 cycle: an operation accepted at edge t is visible on out_c after edge t.
REQ-022 Sustained throughput SHALL be 1 operation/cycle when out_ready is held high.
REQ-023 Results SHALL leave in accept order; none dropped or duplicated.
REQ-024 While out_valid && !out_ready, out_c and out_op SHALL hold stable.
REQ-025 in_a/in_b/in_op SHALL be ignored in cycles without accept.

Reset
REQ-026 rst high at an edge SHALL force state EMPTY, out_valid 0, in_ready 1, out_c 0, out_op 0, skid contents 0, regardless of in-flight data.
REQ-027 Any accept or take coinciding with rst SHALL be discarded; first accept possible the cycle after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the opcode enum (3-bit) and the skid-state enum.
REQ-029 The combinational opcode decode SHALL be one sub-module, bitwise_logic_unit (params N; ports a, b, op, c).

Verification
REQ-030 Reset: rst 2 cycles mid-FULL -> after release out_valid 0, in_ready 1, out_c 8'h00, out_op 0.
REQ-031 Opcode sweep: a=8'hA5, b=8'h3C, op 0..7, out_ready=1 -> out_c A5,5A,24,BD,99,DB,42,66, each one cycle after accept.
REQ-032 Back-pressure: out_ready=0, push op=1 a=8'h0F then op=2 a=8'hFF b=8'hF0 -> FULL, in_ready 0, out_c 8'hF0 held; raise out_ready -> 8'hF0 then 8'hF0 (AND) delivered in order, in_ready 1.
REQ-033 Streaming: 16 back-to-back NOT_A with a=0..15, out_ready=1 -> 16 results ~a in order, one per cycle, in_ready never 0.
REQ-034 Simultaneous accept+take in ONE: out_c 8'h11 taken while a=8'h22 op=0 accepted -> next cycle out_c 8'h22, state ONE.
REQ-035 Random valid/ready toggling, 10k ops, scoreboard -> zero mismatches, no loss, out_c stable whenever stalled.
